// File: rtl/iref_setup_pkg.sv
// Shared types and helpers for the I_REF setup sequencer.
package iref_setup_pkg;

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, DONE, FAILED} setup_state_t;

  localparam int IREF_WIDTH = 10;

  function automatic int unsigned iref_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/iref_setup_seq.sv
// I_REF setup sequencer: sweeps the DAC code down from full scale in STEP
// decrements, settling before each comparator sample, until trip or exhaustion.
module iref_setup_seq
  import iref_setup_pkg::*;
#(
  parameter int WIDTH         = IREF_WIDTH,
  parameter int STEP          = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp,
  output logic [WIDTH-1:0] i_ref_setup,
  output logic             completed,
  output logic             busy,
  output logic             fail
);

  localparam int CNT_W = ($clog2(SETTLE_CYCLES) > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WIDTH-1:0] CODE_MAX = WIDTH'(iref_max(WIDTH));
  localparam logic [WIDTH-1:0] CODE_STEP = WIDTH'(STEP);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  setup_state_t     state;
  logic [CNT_W-1:0] settle_cnt;
  logic             cmp_s;

  sync_2ff u_cmp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmp),
    .q     (cmp_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      i_ref_setup <= CODE_MAX;
      completed   <= 1'b0;
      busy        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, FAILED: begin
          if (start) begin
            state       <= SETTLE;
            settle_cnt  <= CNT_LOAD;
            i_ref_setup <= CODE_MAX;
            completed   <= 1'b0;
            fail        <= 1'b0;
            busy        <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        SAMPLE: begin
          if (cmp_s) begin
            state     <= DONE;
            completed <= 1'b1;
            busy      <= 1'b0;
          end else if (i_ref_setup >= CODE_STEP) begin
            state       <= SETTLE;
            settle_cnt  <= CNT_LOAD;
            i_ref_setup <= i_ref_setup - CODE_STEP;
          end else begin
            // Range exhausted: saturate at zero rather than wrap.
            state       <= FAILED;
            fail        <= 1'b1;
            busy        <= 1'b0;
            i_ref_setup <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          completed <= 1'b0;
          fail      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iref_setup_seq.sv
// Directed self-checking bench for iref_setup_seq (WIDTH=10, STEP=8, SETTLE_CYCLES=4).
module tb_iref_setup_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cmp;
  logic [9:0] i_ref_setup;
  logic       completed;
  logic       busy;
  logic       fail;

  // Comparator model: either forced, or trips once the code is at or below 341.
  logic cmp_model_en;
  logic cmp_force;
  assign cmp = cmp_model_en ? (i_ref_setup <= 10'd341) : cmp_force;

  int vectors;
  int miscompares;
  int edge_no;

  iref_setup_seq #(
    .WIDTH         (10),
    .STEP          (8),
    .SETTLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cmp         (cmp),
    .i_ref_setup (i_ref_setup),
    .completed   (completed),
    .busy        (busy),
    .fail        (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [9:0] code,
                            input logic c, input logic b, input logic f);
    check({tag, ".code"}, 32'(i_ref_setup), 32'(code));
    check({tag, ".completed"}, 32'(completed), 32'(c));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".fail"}, 32'(fail), 32'(f));
  endtask

  // Assert start across one rising edge; that edge becomes edge 0.
  task automatic start_sweep();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edge_no = 0;
  endtask

  task automatic run_to(input int target);
    while (edge_no < target) begin
      @(posedge clk);
      #1;
      edge_no++;
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    edge_no      = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    cmp_model_en = 1'b0;
    cmp_force    = 1'b0;

    // 1. Reset values while rst_n is held low
    repeat (3) @(posedge clk);
    #2;
    check_outs("reset", 10'd1023, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("idle", 10'd1023, 1'b0, 1'b0, 1'b0);

    // 2. Normal sweep, trip at code <= 341 -> 335 decided at edge 435
    cmp_model_en = 1'b1;
    start_sweep();
    check_outs("n.e0", 10'd1023, 1'b0, 1'b1, 1'b0);
    run_to(4);
    check_outs("n.e4", 10'd1023, 1'b0, 1'b1, 1'b0);
    run_to(5);
    check_outs("n.e5", 10'd1015, 1'b0, 1'b1, 1'b0);
    run_to(434);
    check_outs("n.e434", 10'd335, 1'b0, 1'b1, 1'b0);
    run_to(435);
    check_outs("n.e435", 10'd335, 1'b1, 1'b0, 1'b0);
    cmp_model_en = 1'b0;
    cmp_force    = 1'b0;
    run_to(460);
    check_outs("n.hold", 10'd335, 1'b1, 1'b0, 1'b0);

    // 3/5b. Restart from DONE with cmp tied 1: drop, reload MAX, trip at edge 5
    cmp_force = 1'b1;
    run_to(463);
    start_sweep();
    check_outs("t.e0", 10'd1023, 1'b0, 1'b1, 1'b0);
    run_to(4);
    check_outs("t.e4", 10'd1023, 1'b0, 1'b1, 1'b0);
    run_to(5);
    check_outs("t.e5", 10'd1023, 1'b1, 1'b0, 1'b0);

    // 5a/4. cmp tied 0: start pulse in SETTLE at 1015 ignored, fail at edge 640
    cmp_force = 1'b0;
    run_to(10);
    start_sweep();
    run_to(6);
    start = 1'b1;
    run_to(7);
    start = 1'b0;
    run_to(9);
    check_outs("i.e9", 10'd1015, 1'b0, 1'b1, 1'b0);
    run_to(10);
    check_outs("i.e10", 10'd1007, 1'b0, 1'b1, 1'b0);
    run_to(639);
    check_outs("x.e639", 10'd7, 1'b0, 1'b1, 1'b0);
    run_to(640);
    check_outs("x.e640", 10'd0, 1'b0, 1'b0, 1'b1);
    cmp_force = 1'b1;
    run_to(660);
    check_outs("x.hold", 10'd0, 1'b0, 1'b0, 1'b1);

    // 6. Restart from FAILED, async reset mid-settle at code 607
    cmp_force = 1'b0;
    start_sweep();
    check_outs("r.e0", 10'd1023, 1'b0, 1'b1, 1'b0);
    run_to(262);
    check_outs("r.e262", 10'd607, 1'b0, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_outs("r.async", 10'd1023, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    start_sweep();
    check_outs("r2.e0", 10'd1023, 1'b0, 1'b1, 1'b0);
    run_to(5);
    check_outs("r2.e5", 10'd1015, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
